// File: rtl/lcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_seq_pkg
// Description : Shared types for the SPI LCD command sequencer: entry opcodes,
//               sequencer FSM states and a small opcode classification helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_seq_pkg;

  // Entry opcodes as carried on the 2-bit i_op field.
  typedef enum logic [1:0] {
    OP_CMD   = 2'd0,
    OP_DATA  = 2'd1,
    OP_DELAY = 2'd2,
    OP_RESET = 2'd3
  } lcd_op_t;

  // Sequencer states. Only ST_IDLE accepts new entries.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_GAP   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RSTP  = 3'd4
  } lcd_state_t;

  // True for opcodes that put a byte on the SPI wires.
  function automatic logic is_byte_op(input lcd_op_t op);
    return (op == OP_CMD) || (op == OP_DATA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_seq_ctrl_if
// Description : Entry handshake between the CPU-side front end (master) and
//               the LCD sequencer (slave).
//   i_op    [1:0] opcode (CMD/DATA/DELAY/RESET)
//   i_arg   [7:0] byte to send or delay tick count
//   i_valid       entry valid
//   o_ready       sequencer can accept an entry
//   o_busy        inverse of o_ready
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_seq_ctrl_if;

  logic [1:0] i_op;
  logic [7:0] i_arg;
  logic       i_valid;
  logic       o_ready;
  logic       o_busy;

  modport master (
    output i_op,
    output i_arg,
    output i_valid,
    input  o_ready,
    input  o_busy
  );

  modport slave (
    input  i_op,
    input  i_arg,
    input  i_valid,
    output o_ready,
    output o_busy
  );

endinterface
`default_nettype wire

// File: rtl/lcd_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_shifter
// Description : Mode-0 SPI byte shifter, MSB first. Each bit lasts
//               2*SCLK_DIV cycles: SCLK rises after SCLK_DIV cycles and falls
//               after a further SCLK_DIV cycles; MOSI advances on falling
//               edges. After the 8th falling edge SCLK and MOSI rest at 0.
//   clk, rst   core clock, asynchronous active-high reset
//   start_i    load byte_i and begin shifting (first bit visible next cycle)
//   byte_i     byte to send
//   done_o     high in the cycle whose closing edge is the 8th SCLK fall
//   sclk_o     SPI clock (registered)
//   mosi_o     SPI data (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_spi_shifter #(
  parameter int SCLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       done_o,
  output logic       sclk_o,
  output logic       mosi_o
);

  localparam int               c_DW       = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [c_DW-1:0]  c_DIV_LOAD = c_DW'(SCLK_DIV - 1);

  logic            active_q;
  logic            sclk_q;
  // mosi_q is the top bit of the byte; sreg_q holds the remaining 7 bits.
  logic            mosi_q;
  logic [6:0]      sreg_q;
  logic [2:0]      bit_q;
  logic [c_DW-1:0] div_q;

  logic            half_end;

  assign half_end = (div_q == '0);

  // Combinational so the controller can change CS on the same edge as the
  // final SCLK fall.
  assign done_o = active_q & sclk_q & half_end & (bit_q == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      sreg_q   <= '0;
      bit_q    <= '0;
      div_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= byte_i[7];
      sreg_q   <= byte_i[6:0];
      bit_q    <= '0;
      div_q    <= c_DIV_LOAD;
    end else if (active_q) begin
      if (half_end) begin
        div_q <= c_DIV_LOAD;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
        end else begin
          sclk_q <= 1'b0;
          if (bit_q == 3'd7) begin
            active_q <= 1'b0;
            mosi_q   <= 1'b0;
          end else begin
            bit_q  <= bit_q + 3'd1;
            mosi_q <= sreg_q[6];
            sreg_q <= {sreg_q[5:0], 1'b0};
          end
        end
      end else begin
        div_q <= div_q - c_DW'(1);
      end
    end
  end

  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;

endmodule
`default_nettype wire

// File: rtl/lcd_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_seq_ctrl
// Description : Command sequencer for the SPI LCD panel. Consumes 10-bit
//               entries (opcode + argument) over a valid/ready handshake and
//               produces command/data bytes with DC, timed delays and timed
//               panel reset pulses.
//   clk, rst      core clock, asynchronous active-high reset
//   bus (slave)   i_op, i_arg, i_valid, o_ready, o_busy
//   o_lcd_sclk    SPI clock, mode 0
//   o_lcd_mosi    SPI data, MSB first
//   o_lcd_cs_n    panel chip select, active low
//   o_lcd_dc      0 = command, 1 = data
//   o_lcd_rst     panel reset, active low (held low out of reset)
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_seq_ctrl #(
  parameter int SCLK_DIV   = 2,
  parameter int DELAY_UNIT = 12_500
) (
  input  logic           clk,
  input  logic           rst,
  lcd_seq_ctrl_if.slave  bus,
  output logic           o_lcd_sclk,
  output logic           o_lcd_mosi,
  output logic           o_lcd_cs_n,
  output logic           o_lcd_dc,
  output logic           o_lcd_rst
);

  import lcd_seq_pkg::*;

  localparam int c_CW = $clog2(255 * DELAY_UNIT + 1);

  lcd_state_t      state_q, state_d;
  logic            ready_q, ready_d;
  logic            dc_q, dc_d;
  logic            cs_n_q, cs_n_d;
  logic            lrst_q, lrst_d;
  logic [c_CW-1:0] cnt_q, cnt_d;

  logic            shift_start;
  logic            shift_done;
  lcd_op_t         op;
  logic [c_CW-1:0] ticks;

  assign op    = lcd_op_t'(bus.i_op);
  assign ticks = c_CW'(bus.i_arg) * c_CW'(DELAY_UNIT);

  lcd_spi_shifter #(
    .SCLK_DIV (SCLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start_i (shift_start),
    .byte_i  (bus.i_arg),
    .done_o  (shift_done),
    .sclk_o  (o_lcd_sclk),
    .mosi_o  (o_lcd_mosi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      dc_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      lrst_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      dc_q    <= dc_d;
      cs_n_q  <= cs_n_d;
      lrst_q  <= lrst_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter holds "cycles remaining minus one": a state exits on the edge
  // after the counter reads zero, giving exactly N cycles for a load of N-1.
  always_comb begin
    state_d     = state_q;
    dc_d        = dc_q;
    cs_n_d      = cs_n_q;
    lrst_d      = lrst_q;
    cnt_d       = cnt_q;
    shift_start = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_valid && ready_q) begin
          if (is_byte_op(op)) begin
            state_d     = ST_SHIFT;
            dc_d        = bus.i_op[0];
            cs_n_d      = 1'b0;
            shift_start = 1'b1;
          end else if (op == OP_DELAY) begin
            state_d = ST_WAIT;
            cnt_d   = (bus.i_arg == 8'd0) ? '0 : ticks - c_CW'(1);
          end else begin
            // A zero-length reset request still produces one delay unit.
            state_d = ST_RSTP;
            lrst_d  = 1'b0;
            cnt_d   = (bus.i_arg == 8'd0) ? c_CW'(DELAY_UNIT - 1)
                                          : ticks - c_CW'(1);
          end
        end
      end
      ST_SHIFT: begin
        if (shift_done) begin
          state_d = ST_GAP;
          cs_n_d  = 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - c_CW'(1);
        end
      end
      ST_RSTP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          lrst_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - c_CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ready_d     = (state_d == ST_IDLE);

  assign bus.o_ready = ready_q;
  assign bus.o_busy  = ~ready_q;
  assign o_lcd_cs_n  = cs_n_q;
  assign o_lcd_dc    = dc_q;
  assign o_lcd_rst   = lrst_q;

endmodule
`default_nettype wire
